// File: rtl/audio_env_pkg.sv
// audio_env_pkg: shared widths, limits and state encoding for the envelope stage
package audio_env_pkg;
  localparam int ENV_W = 16;
  localparam int SMP_W = 16;
  localparam logic [ENV_W-1:0] ENV_MAX = 16'hFFFF;
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_t;
endpackage

// File: rtl/env_scale.sv
// env_scale: registered signed sample x unsigned envelope multiply, keeping bits [31:16]
module env_scale
  import audio_env_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [SMP_W-1:0] i_sample,
  input  logic [ENV_W-1:0] i_env,
  output logic [SMP_W-1:0] o_sample
);
  logic signed [32:0] w_a;
  logic signed [32:0] w_b;
  logic signed [32:0] w_prod;
  logic               w_unused;
  logic [SMP_W-1:0]   r_sample;
  // the envelope is zero-extended so FFFF means unity gain, not -1
  assign w_a      = {{17{i_sample[SMP_W-1]}}, i_sample};
  assign w_b      = {17'b0, i_env};
  assign w_prod   = w_a * w_b;
  assign w_unused = w_prod[32] ^ (^w_prod[15:0]);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sample <= '0;
    else if (i_en) r_sample <= w_prod[31:16];
  assign o_sample = r_sample;
endmodule

// File: rtl/adsr_envelope.sv
// adsr_envelope: strobe-driven ADSR envelope generator scaling the audio sample stream
module adsr_envelope
  import audio_env_pkg::*;
#(
  parameter logic [ENV_W-1:0] ATK_STEP  = 16'h0040,
  parameter logic [ENV_W-1:0] DEC_STEP  = 16'h0010,
  parameter logic [ENV_W-1:0] SUS_LEVEL = 16'hC000,
  parameter logic [ENV_W-1:0] REL_STEP  = 16'h0008
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_stb,
  input  logic             key_on,
  input  logic [SMP_W-1:0] sample_in,
  output logic [SMP_W-1:0] sample_out,
  output logic             sample_vld,
  output logic [ENV_W-1:0] env_level,
  output logic [2:0]       env_state
);
  env_state_t       r_state, w_nxt_state;
  logic [ENV_W-1:0] r_level, w_nxt_level;
  logic             r_vld;
  logic [ENV_W:0]   w_add, w_dec, w_rel;
  logic [ENV_W-1:0] w_atk_lvl, w_dec_lvl, w_rel_lvl;
  // 17-bit arithmetic exposes carry/borrow for saturation and flooring
  assign w_add     = {1'b0, r_level} + {1'b0, ATK_STEP};
  assign w_dec     = {1'b0, r_level} - {1'b0, DEC_STEP};
  assign w_rel     = {1'b0, r_level} - {1'b0, REL_STEP};
  assign w_atk_lvl = w_add[ENV_W] ? ENV_MAX : w_add[ENV_W-1:0];
  assign w_dec_lvl = (w_dec[ENV_W] || w_dec[ENV_W-1:0] < SUS_LEVEL) ? SUS_LEVEL : w_dec[ENV_W-1:0];
  assign w_rel_lvl = w_rel[ENV_W] ? '0 : w_rel[ENV_W-1:0];
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_level = r_level;
    case (r_state)
      ST_IDLE:    w_nxt_state = key_on ? ST_ATTACK : ST_IDLE;
      ST_ATTACK: begin
        w_nxt_level = key_on ? w_atk_lvl : r_level;
        w_nxt_state = !key_on ? ST_RELEASE : (w_atk_lvl == ENV_MAX) ? ST_DECAY : ST_ATTACK;
      end
      ST_DECAY: begin
        w_nxt_level = key_on ? w_dec_lvl : r_level;
        w_nxt_state = !key_on ? ST_RELEASE : (w_dec_lvl == SUS_LEVEL) ? ST_SUSTAIN : ST_DECAY;
      end
      ST_SUSTAIN: w_nxt_state = key_on ? ST_SUSTAIN : ST_RELEASE;
      ST_RELEASE: begin
        w_nxt_level = key_on ? r_level : w_rel_lvl;
        w_nxt_state = key_on ? ST_ATTACK : (w_rel_lvl == '0) ? ST_IDLE : ST_RELEASE;
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_level = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_level <= '0;
      r_vld   <= 1'b0;
    end else begin
      r_vld <= sample_stb;
      if (sample_stb) begin
        r_state <= w_nxt_state;
        r_level <= w_nxt_level;
      end
    end
  // scaling sees the pre-update level, so it lines up with the same strobe
  env_scale u_scale (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (sample_stb),
    .i_sample (sample_in),
    .i_env    (r_level),
    .o_sample (sample_out)
  );
  assign sample_vld = r_vld;
  assign env_level  = r_level;
  assign env_state  = r_state;
endmodule

// File: tb/tb_adsr_envelope.sv
// tb_adsr_envelope: table vectors, corner sequences and random strobes against an arithmetic envelope model
module tb_adsr_envelope;
  localparam logic [15:0] ATK = 16'h6000, DEC = 16'h2000, SUS = 16'hC000, REL = 16'h4000;
  logic        clk = 0, rst_n = 0, sample_stb = 0, key_on = 0;
  logic [15:0] sample_in = 0, sample_out, env_level;
  logic        sample_vld;
  logic [2:0]  env_state;
  int nvec = 0, nerr = 0;
  int m_st = 0, m_lvl = 0, m_out = 0;
  typedef struct {
    bit          key;
    logic [15:0] smp;
    logic [15:0] lvl;
    logic [2:0]  st;
    logic [15:0] out;
  } vec_t;
  vec_t tbl[$];

  adsr_envelope #(.ATK_STEP(ATK), .DEC_STEP(DEC), .SUS_LEVEL(SUS), .REL_STEP(REL)) dut (
    .clk(clk), .rst_n(rst_n), .sample_stb(sample_stb), .key_on(key_on),
    .sample_in(sample_in), .sample_out(sample_out), .sample_vld(sample_vld),
    .env_level(env_level), .env_state(env_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // envelope rules as plain integer arithmetic: 0 idle,1 attack,2 decay,3 sustain,4 release
  task automatic model(input bit key, input logic [15:0] smp);
    longint p;
    p = longint'($signed(smp)) * longint'(m_lvl);
    m_out = int'((p >>> 16) & 64'hFFFF);
    case (m_st)
      0: if (key) m_st = 1;
      1: if (!key) m_st = 4;
         else begin
           m_lvl = (m_lvl + ATK > 65535) ? 65535 : m_lvl + ATK;
           if (m_lvl == 65535) m_st = 2;
         end
      2: if (!key) m_st = 4;
         else begin
           m_lvl = (m_lvl - int'(DEC) < int'(SUS)) ? int'(SUS) : m_lvl - DEC;
           if (m_lvl == SUS) m_st = 3;
         end
      3: if (!key) m_st = 4;
      default: if (key) m_st = 1;
         else begin
           m_lvl = (m_lvl - int'(REL) < 0) ? 0 : m_lvl - REL;
           if (m_lvl == 0) m_st = 0;
         end
    endcase
  endtask

  task automatic apply(input bit stb, input bit key, input logic [15:0] smp, input string tag);
    sample_stb = stb;
    key_on     = key;
    sample_in  = smp;
    if (stb) model(key, smp);
    @(negedge clk);
    chk({tag, " vld"}, 32'(sample_vld), 32'(stb));
    chk({tag, " level"}, 32'(env_level), m_lvl);
    chk({tag, " state"}, 32'(env_state), m_st);
    chk({tag, " out"}, 32'(sample_out), m_out);
  endtask

  initial begin
    bit key;
    tbl.push_back('{0, 16'h1234, 16'h0000, 3'd0, 16'h0000});
    tbl.push_back('{1, 16'h7FFF, 16'h0000, 3'd1, 16'h0000});
    tbl.push_back('{1, 16'h7FFF, 16'h6000, 3'd1, 16'h0000});
    tbl.push_back('{1, 16'h7FFF, 16'hC000, 3'd1, 16'h2FFF});
    tbl.push_back('{1, 16'h7FFF, 16'hFFFF, 3'd2, 16'h5FFF});
    tbl.push_back('{1, 16'h7FFF, 16'hDFFF, 3'd2, 16'h7FFE});
    tbl.push_back('{1, 16'h0000, 16'hC000, 3'd3, 16'h0000});
    tbl.push_back('{1, 16'h0000, 16'hC000, 3'd3, 16'h0000});
    tbl.push_back('{0, 16'h0000, 16'hC000, 3'd4, 16'h0000});
    tbl.push_back('{0, 16'h0000, 16'h8000, 3'd4, 16'h0000});
    tbl.push_back('{1, 16'h8000, 16'h8000, 3'd1, 16'hC000});
    tbl.push_back('{1, 16'h0000, 16'hE000, 3'd1, 16'h0000});
    tbl.push_back('{0, 16'h0000, 16'hE000, 3'd4, 16'h0000});
    tbl.push_back('{0, 16'h0000, 16'hA000, 3'd4, 16'h0000});
    tbl.push_back('{0, 16'h0000, 16'h6000, 3'd4, 16'h0000});
    tbl.push_back('{0, 16'h0000, 16'h2000, 3'd4, 16'h0000});
    tbl.push_back('{0, 16'h0000, 16'h0000, 3'd0, 16'h0000});
    tbl.push_back('{0, 16'h0000, 16'h0000, 3'd0, 16'h0000});
    tbl.push_back('{1, 16'hFFFF, 16'h0000, 3'd1, 16'h0000});

    repeat (2) @(negedge clk);
    chk("rst level", 32'(env_level), 0);
    chk("rst state", 32'(env_state), 0);
    chk("rst out", 32'(sample_out), 0);
    chk("rst vld", 32'(sample_vld), 0);
    rst_n = 1;
    @(negedge clk);

    foreach (tbl[i]) begin
      sample_stb = 1;
      key_on     = tbl[i].key;
      sample_in  = tbl[i].smp;
      model(tbl[i].key, tbl[i].smp);
      @(negedge clk);
      chk($sformatf("tbl%0d vld", i), 32'(sample_vld), 1);
      chk($sformatf("tbl%0d level", i), 32'(env_level), 32'(tbl[i].lvl));
      chk($sformatf("tbl%0d state", i), 32'(env_state), 32'(tbl[i].st));
      chk($sformatf("tbl%0d out", i), 32'(sample_out), 32'(tbl[i].out));
    end

    apply(1, 1, 16'h7FFF, "atk1");
    apply(1, 1, 16'h7FFF, "atk2");
    apply(0, 1, 16'h7FFF, "atk_hold");
    #2 rst_n = 0;
    #1;
    chk("async level", 32'(env_level), 0);
    chk("async state", 32'(env_state), 0);
    chk("async out", 32'(sample_out), 0);
    m_st = 0; m_lvl = 0; m_out = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (3) apply(1, 0, 16'h4321, "idle_stb");

    for (int n = 0; n < 20 && m_st != 3; n++) apply(1, 1, 16'h1000, "to_sus");
    chk("reached sustain", 32'(env_state), 3);
    for (int n = 0; n < 10; n++) begin
      apply(1, 1, 16'h7FFF, "sus");
      chk("sus hold", 32'(env_level), 32'(SUS));
    end

    for (int n = 0; n < 6; n++) apply(0, n[0], 16'h5555, "gate");
    for (int n = 0; n < 3; n++) apply(1, 0, 16'h2222, "b2b");
    apply(0, 0, 16'h0000, "b2b_end");

    key = 0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(7) == 0) key = !key;
      apply(1, key, 16'($urandom), "rnd");
      repeat ($urandom_range(2)) apply(0, $urandom_range(1) == 1, 16'($urandom), "rnd_gap");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/adsr_envelope.md
# adsr_envelope

Amplitude-envelope stage between the sine generator and the I2S transmitter in the keyboard synthesizer. On each audio sample strobe it advances a five-state ADSR envelope driven by the key-held level, then scales the incoming signed 16-bit sample by the envelope. The scaled sample is the audio data word passed to the I2S stage. Without this stage, notes start and stop with audible clicks; with it, note-on and note-off ramp smoothly.

## Interface
- `ATK_STEP`, default 16'h0040: envelope increment per strobe in ATTACK.
- `DEC_STEP`, default 16'h0010: envelope decrement per strobe in DECAY.
- `SUS_LEVEL`, default 16'hC000: sustain level; DECAY floor.
- `REL_STEP`, default 16'h0008: envelope decrement per strobe in RELEASE.
- `clk`  in  1: system clock (CLOCK_50 domain).
- `rst_n`  in  1: reset; one clock, reset is asynchronous and active-low.
- `sample_stb`  in  1: one-cycle pulse per audio sample, already synchronous to `clk`.
- `key_on`  in  1: level signal; 1 while a note key is held.
- `sample_in`  in  16: signed two's-complement sample from the sine generator.
- `sample_out`  out  16: signed scaled sample to the I2S stage.
- `sample_vld`  out  1: one-cycle pulse when `sample_out` updates.
- `env_level`  out  16: current unsigned envelope value (0 = silent, FFFF = full).
- `env_state`  out  3: current FSM state encoding, for LEDs and debug.

## Operation
- States: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- State, `env_level`, and `key_on` sampling all act only on cycles where `sample_stb`=1. All other cycles hold state.
- IDLE:
  - `env_level` is 0.
  - If `key_on`=1, go to ATTACK. The first increment happens on the next strobe.
- ATTACK:
  - If `key_on`=0, go to RELEASE with no level change.
  - Otherwise `env_level` += `ATK_STEP`, computed 17-bit and saturated at FFFF.
  - On reaching FFFF, go to DECAY.
- DECAY:
  - If `key_on`=0, go to RELEASE.
  - Otherwise `env_level` -= `DEC_STEP`, floored at `SUS_LEVEL`.
  - On reaching `SUS_LEVEL`, go to SUSTAIN.
- SUSTAIN:
  - Hold `env_level`.
  - If `key_on`=0, go to RELEASE.
- RELEASE:
  - If `key_on`=1, go to ATTACK. This is a retrigger: the level is kept, not zeroed.
  - Otherwise `env_level` -= `REL_STEP`, floored at 0.
  - On reaching 0, go to IDLE.
- Scaling:
  - Form the 33-bit signed product `sample_in` × {1'b0, `env_level`}.
  - `sample_out` = product[31:16], which is an arithmetic shift right by 16.
  - The product uses the `env_level` value from before that strobe's update.
- Boundaries:
  - `SUS_LEVEL`=FFFF: DECAY exits to SUSTAIN on its first strobe.
  - `SUS_LEVEL`=0: the sustain level is silent.
  - A step of 0 in any ramp state holds that state indefinitely. This is legal and is not an error.

## Timing
- Reset values: `sample_out`=0, `sample_vld`=0, `env_level`=0, `env_state`=IDLE.
- Reset asserted mid-note forces IDLE immediately, independent of `clk`.
- Latency: a strobe at cycle N gives `sample_out`, the new `env_level`/`env_state`, and a `sample_vld` pulse all registered at cycle N+1.
- Back-to-back strobes on consecutive cycles are each processed fully. There is no throughput limit.
- `key_on` changing between strobes has no effect until the next strobe. Glitches shorter than a sample period are ignored.

## Structure
- Shared package `audio_env_pkg`:
  - `env_state_t` enum (3-bit, encodings above).
  - `ENV_W`=16, `SMP_W`=16, `ENV_MAX`=16'hFFFF.
- One sub-module `env_scale`: registered signed 16×17 multiply with [31:16] selection. This keeps the DSP inference isolated.
- FSM and saturating add/subtract live in the top level of this block.
- Top-level wiring: `sample_stb` is the `clk`-synchronized rising edge of AUD_DACLRCK.

## Test plan
1. Reset and idle:
   - Assert `rst_n`=0 mid-ATTACK → `env_level`=0, `env_state`=0, `sample_out`=0 asynchronously.
   - Release reset; strobes with `key_on`=0 → state stays IDLE, `sample_out`=0.
2. Attack saturation:
   - Set `ATK_STEP`=16'h6000, `key_on`=1, `sample_in`=16'h7FFF.
   - `env_level` must read 0 → 6000 → C000 → FFFF, ending in DECAY.
   - The strobe after reaching FFFF gives `sample_out`=16'h7FFE.
3. Decay floor:
   - Set `DEC_STEP`=16'h2000, `SUS_LEVEL`=16'hC000.
   - From FFFF: DFFF → C000 (floored), state SUSTAIN. Level holds at C000 for 10 strobes.
4. Release and retrigger:
   - Set `key_on`=0 in SUSTAIN with `REL_STEP`=16'h4000 → C000 → 8000.
   - Set `key_on`=1 → ATTACK resumes from 8000, not 0.
   - Later `key_on`=0 → level falls to 0, then IDLE.
5. Negative scaling:
   - With `env_level`=8000, drive `sample_in`=16'h8000 (−32768) → `sample_out`=16'hC000 (−16384).
   - `sample_vld` is high exactly one cycle after the strobe.
6. Strobe gating:
   - Toggle `key_on` between strobes, with no strobe in the window → no state change and no `sample_vld`.
   - Drive strobes on 3 consecutive cycles → exactly 3 updates.
